// File: rtl/noisy_signal_if.sv
// Sample stream bundle for noisy_signal_src: control inputs, ready/valid handshake and count.
// master is the generator side; slave is the controlling/consuming side.
interface noisy_signal_if;
  logic        enable;
  logic        noise_en;
  logic [15:0] phase_inc;
  logic        sample_ready;
  logic [15:0] noisy_signal;
  logic        sample_valid;
  logic [15:0] sample_count;

  modport master (
    input  enable, noise_en, phase_inc, sample_ready,
    output noisy_signal, sample_valid, sample_count
  );

  modport slave (
    output enable, noise_en, phase_inc, sample_ready,
    input  noisy_signal, sample_valid, sample_count
  );
endinterface

// File: rtl/noisy_signal_src.sv
// Triangle-wave generator at half scale with optional Galois-LFSR noise, saturated to 16 bits,
// delivered over a ready/valid stream with an accepted-sample counter.
module noisy_signal_src #(
  parameter int unsigned NOISE_SHIFT = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input logic            clk,
  input logic            rst,
  noisy_signal_if.master bus
);

  logic [15:0] phase;
  logic [15:0] lfsr;
  logic [15:0] sample_q;
  logic        valid_q;
  logic [15:0] count_q;

  logic               load;
  logic               accept;
  logic [14:0]        tri_mag;
  logic signed [15:0] tri_w;
  logic signed [15:0] half;
  logic signed [15:0] noise;
  logic signed [16:0] sum;
  logic [15:0]        sat;
  logic [15:0]        lfsr_next;

  // A held sample can be replaced in the same edge it is consumed, giving one sample per clock.
  assign load   = bus.enable && (!valid_q || bus.sample_ready);
  assign accept = valid_q && bus.sample_ready;

  // NOTE: every signal gets a value on every path through always_comb, so no latch can be inferred.
  always_comb begin
    tri_mag   = phase[15] ? ~phase[14:0] : phase[14:0];
    tri_w     = $signed({tri_mag, 1'b0} ^ 16'h8000);
    half      = tri_w >>> 1;
    noise     = bus.noise_en ? ($signed(lfsr) >>> NOISE_SHIFT) : 16'sd0;
    sum       = {half[15], half} + {noise[15], noise};
    sat       = sum[15:0];
    // Top two bits disagree only when the 17-bit sum left the 16-bit range.
    if (sum[16] != sum[15]) sat = sum[16] ? 16'h8000 : 16'h7FFF;
    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  // NOTE: non-blocking assignments keep every register reading the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= 16'h0000;
      lfsr     <= LFSR_SEED;
      sample_q <= 16'h0000;
      valid_q  <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      if (load) begin
        sample_q <= sat;
        valid_q  <= 1'b1;
        phase    <= phase + bus.phase_inc;
        lfsr     <= lfsr_next;
      end else if (accept) begin
        valid_q  <= 1'b0;
      end
      if (accept) count_q <= count_q + 16'd1;
    end
  end

  assign bus.noisy_signal = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.sample_count = count_q;

endmodule

// File: tb/tb_noisy_signal_src.sv
// Self-checking bench for noisy_signal_src: an arithmetic reference model compared every cycle,
// plus hand-computed literal expectations for ramp, noise, backpressure, reset, saturation and wrap.
module tb_noisy_signal_src;

  localparam int M_SHIFT = 4;
  localparam int M_SEED  = 'hACE1;

  logic clk;
  logic rst;

  noisy_signal_if bus1 ();
  noisy_signal_if bus2 ();

  noisy_signal_src dut1 (.clk(clk), .rst(rst), .bus(bus1));

  noisy_signal_src #(.NOISE_SHIFT(0), .LFSR_SEED(16'h8000)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 0;

  // Reference model state, in plain integers.
  int m_p     = 0;
  int m_l     = M_SEED;
  int m_out   = 0;
  int m_valid = 0;
  int m_cnt   = 0;
  bit m_ld, m_acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Triangle at half scale equals (folded phase) - 16384; noise is a floor division by 2^shift.
  function automatic int model_sample(input int p, input int l, input bit with_noise);
    int t, h, ls, n, s;
    t  = (p < 32768) ? p : 65535 - p;
    h  = t - 16384;
    ls = (l >= 32768) ? l - 65536 : l;
    n  = with_noise ? (ls >>> M_SHIFT) : 0;
    s  = h + n;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return s & 'hFFFF;
  endfunction

  function automatic int model_lfsr(input int l);
    return (l / 2) ^ ((l % 2 == 1) ? 'hB400 : 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p = 0; m_l = M_SEED; m_out = 0; m_valid = 0; m_cnt = 0;
    end else begin
      m_acc = (m_valid == 1) && bus1.sample_ready;
      m_ld  = bus1.enable && ((m_valid == 0) || bus1.sample_ready);
      if (m_ld) begin
        m_out   = model_sample(m_p, m_l, bus1.noise_en);
        m_p     = (m_p + int'(bus1.phase_inc)) % 65536;
        m_l     = model_lfsr(m_l);
        m_valid = 1;
      end else if (m_acc) begin
        m_valid = 0;
      end
      if (m_acc) m_cnt = (m_cnt + 1) % 65536;
    end
  end

  always @(negedge clk) begin
    if (cmp_on && !rst) begin
      check("m_valid", 32'(bus1.sample_valid), 32'(m_valid));
      check("m_count", 32'(bus1.sample_count), 32'(m_cnt));
      if (m_valid == 1) check("m_sample", 32'(bus1.noisy_signal), 32'(m_out));
      check("m_phase", 32'(dut1.phase), 32'(m_p));
      check("m_lfsr", 32'(dut1.lfsr), 32'(m_l));
    end
  end

  initial begin
    int saved_p, saved_l;
    rst = 1'b1;
    bus1.enable = 1'b0; bus1.noise_en = 1'b0; bus1.phase_inc = 16'h0; bus1.sample_ready = 1'b0;
    bus2.enable = 1'b0; bus2.noise_en = 1'b1; bus2.phase_inc = 16'h0; bus2.sample_ready = 1'b1;

    #2;
    check("rst_valid", 32'(bus1.sample_valid), 32'h0);
    check("rst_sample", 32'(bus1.noisy_signal), 32'h0);
    check("rst_count", 32'(bus1.sample_count), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmp_on = 1'b1;

    // Noise-free ramp; saturation block runs alongside.
    bus1.noise_en = 1'b0; bus1.phase_inc = 16'h0100; bus1.sample_ready = 1'b1; bus1.enable = 1'b1;
    bus2.enable = 1'b1;
    @(negedge clk);
    check("ramp0", 32'(bus1.noisy_signal), 32'hC000);
    check("ramp0_cnt", 32'(bus1.sample_count), 32'd0);
    check("sat0", 32'(bus2.noisy_signal), 32'h8000);
    @(negedge clk);
    check("ramp1", 32'(bus1.noisy_signal), 32'hC100);
    check("ramp1_cnt", 32'(bus1.sample_count), 32'd1);
    check("sat1", 32'(bus2.noisy_signal), 32'h0000);
    bus2.enable = 1'b0;
    @(negedge clk);
    check("ramp2", 32'(bus1.noisy_signal), 32'hC200);
    bus1.enable = 1'b0;
    @(negedge clk);
    check("stop_valid", 32'(bus1.sample_valid), 32'h0);
    check("stop_cnt", 32'(bus1.sample_count), 32'd3);

    // Pending sample discarded by an asynchronous reset between edges.
    bus1.enable = 1'b1; bus1.sample_ready = 1'b0;
    @(negedge clk);
    check("pend_valid", 32'(bus1.sample_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", 32'(bus1.sample_valid), 32'h0);
    check("arst_sample", 32'(bus1.noisy_signal), 32'h0);
    check("arst_count", 32'(bus1.sample_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Noise with default parameters, then backpressure for 5 cycles.
    bus1.noise_en = 1'b1; bus1.phase_inc = 16'h0; bus1.sample_ready = 1'b1;
    @(negedge clk);
    check("noise0", 32'(bus1.noisy_signal), 32'hBACE);
    check("noise0_lfsr", 32'(dut1.lfsr), 32'hE270);
    bus1.sample_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_sample", 32'(bus1.noisy_signal), 32'hBACE);
      check("bp_count", 32'(bus1.sample_count), 32'd0);
    end
    bus1.sample_ready = 1'b1;
    @(negedge clk);
    check("noise1", 32'(bus1.noisy_signal), 32'hBE27);
    check("noise1_cnt", 32'(bus1.sample_count), 32'd1);

    // Stream 65537 accepted samples, then stop.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus1.phase_inc = 16'h1234;
    repeat (65538) @(negedge clk);
    check("wrap_cnt", 32'(bus1.sample_count), 32'd1);
    saved_p = m_p;
    saved_l = m_l;
    bus1.enable = 1'b0;
    @(negedge clk);
    check("final_valid", 32'(bus1.sample_valid), 32'h0);
    check("final_cnt", 32'(bus1.sample_count), 32'd2);
    check("final_phase", 32'(dut1.phase), 32'(saved_p));
    check("final_lfsr", 32'(dut1.lfsr), 32'(saved_l));
    @(negedge clk);
    check("idle_valid", 32'(bus1.sample_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
